simplecircuit_sequencer: RTL and testbench
==========================================

SIMPLECIRCUIT_SEQUENCER -- requirements
Module: simplecircuit_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 6, sets the number of clock cycles allowed for the gate network to settle after inputs change; legal range 1..255.
REQ-002 Parameter CNT_W, default 8, sets the width of both status counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  test vector offered.
REQ-006 in_vec  input  3  vector {A,B,C}: bit2=A, bit1=B, bit0=C.
REQ-007 in_ready  output  1  sequencer accepts a vector; equals 1 only in state IDLE.
REQ-008 circ_a, circ_b, circ_c  output  1 each  registered drive to the gate network's A, B, C inputs.
REQ-009 circ_d, circ_e  input  1 each  gate network outputs D and E, sampled only at capture.
REQ-010 out_valid  output  1  captured result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_d, out_e  output  1 each  captured D and E.
REQ-013 out_err  output  1  captured {D,E} differs from the expected {D,E}.
REQ-014 vec_cnt  output  CNT_W  number of completed captures; wraps modulo 2^CNT_W.
REQ-015 err_cnt  output  CNT_W  number of mismatching captures; saturates at 2^CNT_W-1.

Function
REQ-016 The controller SHALL have exactly three states: IDLE, SETTLE and HOLD.
REQ-017 IDLE: on an edge where in_valid=1, circ_{a,b,c} SHALL load in_vec, the settle counter SHALL clear to 0, and the state SHALL become SETTLE.
REQ-018 SETTLE: the settle counter SHALL increment each cycle, and in_valid SHALL be ignored.
REQ-019 On the edge where the settle counter equals SETTLE_CYCLES-1, the block SHALL:
  - capture circ_d and circ_e into out_d and out_e;
  - compute out_err;
  - set out_valid=1;
  - update both counters;
  - move to HOLD.
REQ-020 Latency SHALL be exactly SETTLE_CYCLES cycles from the accepting edge to the edge that asserts out_valid.
REQ-021 The expected result SHALL be exp_d = (circ_a AND circ_b) OR NOT circ_c and exp_e = NOT circ_c.
REQ-022 out_err SHALL be set to ({circ_d,circ_e} != {exp_d,exp_e}).
REQ-023 HOLD: out_valid, out_d, out_e and out_err SHALL stay stable until an edge where out_ready=1; at that edge out_valid SHALL clear and the state SHALL return to IDLE.
REQ-024 The block SHALL NOT provide a HOLD->SETTLE bypass; a new vector is accepted no earlier than the edge after the one that clears out_valid.
REQ-025 circ_{a,b,c} SHALL retain the last vector in IDLE and HOLD; they change only on acceptance.
REQ-026 On every capture, vec_cnt SHALL increment and wrap from 2^CNT_W-1 to 0.
REQ-027 On a capture with out_err=1, err_cnt SHALL increment unless it is already all-ones.
REQ-028 X or Z on circ_d or circ_e at capture SHALL count as a mismatch.

Reset
REQ-029 When rst=1 at an edge, the block SHALL apply all of the following on that edge, whatever the state:
  - state=IDLE and settle counter=0;
  - circ_a=circ_b=circ_c=0;
  - out_valid=out_d=out_e=out_err=0;
  - vec_cnt=err_cnt=0.
REQ-030 When rst and in_valid are both 1 on the same edge, reset SHALL win and no vector SHALL be accepted.
REQ-031 A reset during SETTLE or HOLD SHALL abandon the vector with no out_valid pulse and no counter update.

Verification
REQ-032 All scenarios SHALL run with SETTLE_CYCLES=6, a 10 ns clock and the delayed gate network (AND 30, NOT 10, OR 20; worst path 50 ns) attached:
  - Reset: rst held for 2 cycles -> all outputs 0, in_ready=1.
  - Nominal: in_vec=3'b111 accepted at edge k -> out_valid=1 at edge k+6, out_d=1, out_e=0, out_err=0, vec_cnt=1.
  - Backpressure: out_ready=0 for 4 cycles after out_valid, in_valid=1 throughout -> outputs stable, in_ready=0, no second acceptance; out_ready=1 -> IDLE, next vector accepted one edge later.
  - Fault: circ_d forced 0, in_vec=3'b000 -> out_d=0, out_e=1, out_err=1, err_cnt=1.
  - Mid-op reset: rst=1 three cycles after acceptance -> IDLE on that edge, out_valid never rises, counters remain 0.
  - Counter limits: CNT_W=2, five mismatching vectors -> err_cnt=3 (saturated), vec_cnt=1 (wrapped).

Source files
------------

// File: rtl/simplecircuit_sequencer.sv
// Test-vector sequencer for a small gate network: drives {A,B,C}, waits a fixed
// settle time, captures {D,E}, checks them against the ideal function and keeps counters.
`timescale 1ns/1ps
module simplecircuit_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 6,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [2:0]       in_vec,
   output logic             in_ready,
   output logic             circ_a,
   output logic             circ_b,
   output logic             circ_c,
   input  logic             circ_d,
   input  logic             circ_e,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_d,
   output logic             out_e,
   output logic             out_err,
   output logic [CNT_W-1:0] vec_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned SC_W = 8;
   localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_e;

   state_e            state_q;
   logic [SC_W-1:0]   settle_q;
   logic [2:0]        circ_q;
   logic              ready_q;
   logic              out_valid_q;
   logic              out_d_q;
   logic              out_e_q;
   logic              out_err_q;
   logic [CNT_W-1:0]  vec_cnt_q;
   logic [CNT_W-1:0]  err_cnt_q;

   logic              exp_d_c;
   logic              exp_e_c;
   logic              out_err_d;

   // Ideal network response; case inequality makes X/Z on D/E a mismatch.
   assign exp_d_c   = (circ_q[2] & circ_q[1]) | ~circ_q[0];
   assign exp_e_c   = ~circ_q[0];
   assign out_err_d = ({circ_d, circ_e} !== {exp_d_c, exp_e_c});

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         settle_q    <= '0;
         circ_q      <= '0;
         ready_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_d_q     <= 1'b0;
         out_e_q     <= 1'b0;
         out_err_q   <= 1'b0;
         vec_cnt_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  circ_q   <= in_vec;
                  settle_q <= '0;
                  ready_q  <= 1'b0;
                  state_q  <= SETTLE;
               end
            end
            SETTLE: begin
               settle_q <= settle_q + SC_W'(1);
               if (settle_q == SETTLE_LAST) begin
                  out_d_q     <= circ_d;
                  out_e_q     <= circ_e;
                  out_err_q   <= out_err_d;
                  out_valid_q <= 1'b1;
                  vec_cnt_q   <= vec_cnt_q + CNT_W'(1);
                  if (out_err_d && (err_cnt_q != '1)) begin
                     err_cnt_q <= err_cnt_q + CNT_W'(1);
                  end
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               // No bypass to SETTLE: acceptance only happens from IDLE.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = ready_q;
   assign circ_a    = circ_q[2];
   assign circ_b    = circ_q[1];
   assign circ_c    = circ_q[0];
   assign out_valid = out_valid_q;
   assign out_d     = out_d_q;
   assign out_e     = out_e_q;
   assign out_err   = out_err_q;
   assign vec_cnt   = vec_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_simplecircuit_sequencer.sv
// Scoreboard bench for simplecircuit_sequencer with a delayed gate network attached,
// plus a second instance with 2-bit counters for wrap/saturation.
`timescale 1ns/1ps
module tb_simplecircuit_sequencer;

   localparam int unsigned SETTLE = 6;

   typedef struct packed {
      logic        d;
      logic        e;
      logic        err;
      logic [7:0]  vc;
      logic [7:0]  ec;
      logic [31:0] due;
   } exp_t;

   logic clk = 1'b0;
   logic rst, rst2, in_valid, out_ready, fault, sel2;
   logic [2:0] in_vec;

   logic in_ready, ca, cb, cc, cd, ce, out_valid, out_d, out_e, out_err;
   logic [7:0] vec_cnt, err_cnt;
   logic in_ready2, ca2, cb2, cc2, cd2, ce2, out_valid2, out_d2, out_e2, out_err2;
   logic [1:0] vec_cnt2, err_cnt2;

   logic ab_n, nc_n, d_n;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rises    = 0;
   logic ov_prev = 1'b0;
   logic [7:0] mvec = 8'd0;
   logic [7:0] merr = 8'd0;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Gate network: AND 30, NOT 10, OR 20; fault pins D low.
   assign #30 ab_n = ca & cb;
   assign #10 nc_n = ~cc;
   assign #20 d_n  = ab_n | nc_n;
   assign cd = fault ? 1'b0 : d_n;
   assign ce = nc_n;

   // Second instance always sees a wrong D.
   assign cd2 = ~((ca2 & cb2) | ~cc2);
   assign ce2 = ~cc2;

   simplecircuit_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready),
      .circ_a(ca), .circ_b(cb), .circ_c(cc), .circ_d(cd), .circ_e(ce),
      .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_e(out_e),
      .out_err(out_err), .vec_cnt(vec_cnt), .err_cnt(err_cnt)
   );

   simplecircuit_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst2), .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready2),
      .circ_a(ca2), .circ_b(cb2), .circ_c(cc2), .circ_d(cd2), .circ_e(ce2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_d(out_d2), .out_e(out_e2),
      .out_err(out_err2), .vec_cnt(vec_cnt2), .err_cnt(err_cnt2)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [2:0] v, input bit flt, input int due);
      exp_t x;
      logic ed, ee, ad;
      ed = (v[2] & v[1]) | ~v[0];
      ee = ~v[0];
      ad = flt ? 1'b0 : ed;
      x.d   = ad;
      x.e   = ee;
      x.err = (ad != ed);
      mvec  = mvec + 8'd1;
      if (x.err && merr != 8'hff) merr = merr + 8'd1;
      x.vc  = mvec;
      x.ec  = merr;
      x.due = 32'(due);
      sbq.push_back(x);
   endtask

   // Offer one vector at the next edge the selected DUT is ready.
   task automatic send(input logic [2:0] v, input bit flt, input bit push);
      int n;
      n = 0;
      @(negedge clk);
      while (!(sel2 ? in_ready2 : in_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready_wait", 32'(sel2 ? in_ready2 : in_ready), 32'd1);
      fault    = flt;
      in_valid = 1'b1;
      in_vec   = v;
      if (push) push_exp(v, flt, cyc + 1 + SETTLE);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!(sbq.size() == 0 && in_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sbq.size() == 0 && in_ready), 32'd1);
   endtask

   // Monitor: compare each new result against the scoreboard head.
   always @(posedge clk) begin
      exp_t x;
      #1;
      if (out_valid && !ov_prev) begin
         rises++;
         if (sbq.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            x = sbq.pop_front();
            chk("latency", 32'(cyc), x.due);
            chk("out_d", 32'(out_d), 32'(x.d));
            chk("out_e", 32'(out_e), 32'(x.e));
            chk("out_err", 32'(out_err), 32'(x.err));
            chk("vec_cnt", 32'(vec_cnt), 32'(x.vc));
            chk("err_cnt", 32'(err_cnt), 32'(x.ec));
         end
      end
      ov_prev = out_valid;
   end

   initial begin
      int r0;
      logic [2:0] v;
      bit f;
      rst = 1'b1; rst2 = 1'b1; in_valid = 1'b0; in_vec = 3'b000;
      out_ready = 1'b1; fault = 1'b0; sel2 = 1'b0;

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_circ", 32'({ca, cb, cc}), 32'd0);
      chk("rst_outs", 32'({out_valid, out_d, out_e, out_err}), 32'd0);
      chk("rst_cnts", 32'({vec_cnt, err_cnt}), 32'd0);
      rst = 1'b0;

      // Nominal
      send(3'b111, 1'b0, 1'b1);
      drain();

      // Backpressure
      out_ready = 1'b0;
      send(3'b111, 1'b0, 1'b1);
      r0 = 0;
      while (!out_valid && r0 < 50) begin
         @(negedge clk);
         r0++;
      end
      chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      in_vec   = 3'b010;
      for (int i = 0; i < 4; i++) begin
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_outs", 32'({out_d, out_e, out_err}), 32'b100);
         chk("bp_circ", 32'({ca, cb, cc}), 32'b111);
         @(negedge clk);
      end
      push_exp(3'b010, 1'b0, cyc + 2 + SETTLE);
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      chk("bp_release_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_accept_ready", 32'(in_ready), 32'd0);
      chk("bp_accept_circ", 32'({ca, cb, cc}), 32'b010);
      drain();

      // Fault: D stuck low
      send(3'b000, 1'b1, 1'b1);
      drain();
      chk("fault_err_cnt", 32'(err_cnt), 32'd1);

      // Mixed vectors, some with the fault
      for (int i = 0; i < 8; i++) begin
         v = 3'($urandom_range(0, 7));
         f = 1'($urandom_range(0, 1));
         send(v, f, 1'b1);
      end
      drain();
      chk("mix_vec_cnt", 32'(vec_cnt), 32'(mvec));
      chk("mix_err_cnt", 32'(err_cnt), 32'(merr));

      // Mid-operation reset three edges after acceptance
      r0 = rises;
      send(3'b101, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mvec = 8'd0;
      merr = 8'd0;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_circ", 32'({ca, cb, cc}), 32'd0);
      chk("mid_rst_cnts", 32'({vec_cnt, err_cnt}), 32'd0);
      repeat (10) @(negedge clk);
      chk("mid_rst_no_valid", 32'(rises - r0), 32'd0);
      chk("mid_rst_cnts_hold", 32'({vec_cnt, err_cnt}), 32'd0);
      send(3'b110, 1'b0, 1'b1);
      drain();

      // Counter limits on the 2-bit instance
      rst = 1'b1;
      @(negedge clk);
      rst2 = 1'b0;
      sel2 = 1'b1;
      for (int i = 0; i < 5; i++) send(3'($urandom_range(0, 7)), 1'b0, 1'b0);
      r0 = 0;
      while (!in_ready2 && r0 < 50) begin
         @(negedge clk);
         r0++;
      end
      chk("lim_ready", 32'(in_ready2), 32'd1);
      chk("lim_err_cnt", 32'(err_cnt2), 32'd3);
      chk("lim_vec_cnt", 32'(vec_cnt2), 32'd1);
      chk("lim_out_err", 32'(out_err2), 32'd1);
      chk("sb_empty", 32'(sbq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
